instr_mem_responder: RTL
========================

Name: instr_mem_responder

Overview:
Synthesizable instruction-memory responder for the core's instruction fetch interface (instr_req/gnt/addr/rvalid/rdata); it is the memory-side end of the protocol the core initiates. It holds N_WORDS 32-bit words, grants fetch requests, and returns read data after a fixed, pipelined latency. A load port preloads program words. It replaces behavioural testbench memory models and is the on-chip boot/instruction RAM in FPGA builds.

Parameters:
ADDR_WIDTH, 32, width of instr_addr_i.
N_WORDS, 16, number of 32-bit words stored; power of two, 4..4096.
BASE_ADDR, 32'h0000_0000, byte address of word 0; 4-byte aligned.
READ_LATENCY, 1, cycles from grant cycle to rvalid; legal 1..4.
IDX_W, $clog2(N_WORDS), word index width; derived, not overridden.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
instr_req_i  in  1  fetch request from core
instr_addr_i  in  ADDR_WIDTH  fetch byte address
instr_gnt_o  out  1  request accepted this cycle (combinational)
instr_rvalid_o  out  1  response valid, one cycle per granted request
instr_rdata_o  out  32  response data
instr_err_o  out  1  response is for an out-of-range address; valid with rvalid
load_we_i  in  1  preload write strobe
load_idx_i  in  IDX_W  preload word index
load_wdata_i  in  32  preload data
gnt_cnt_o  out  16  saturating count of granted requests

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, gnt_cnt_o=0, all response-pipeline valid bits 0. Memory array is not reset.
- Grant: instr_gnt_o = instr_req_i & ~load_we_i (& stall term, see Optional Feature). No state gates it: responder accepts one request every cycle, with up to READ_LATENCY requests outstanding.
- Address decode: in_range = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 4*N_WORDS); idx = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
- Read is sampled in the grant cycle: stage 0 captures {valid=1, err=~in_range, data = in_range ? mem[idx] : 32'h0}.
- Pipeline: READ_LATENCY-deep shift register of {valid, err, data}. The last stage drives instr_rvalid_o/instr_err_o/instr_rdata_o, so rvalid rises exactly READ_LATENCY cycles after the grant edge. Responses are returned in grant order with no backpressure. When no response is valid, rdata holds its last value and err=0.
- Back-to-back: grants on consecutive cycles give rvalid on consecutive cycles; throughput is 1 word/cycle for any READ_LATENCY.
- Out-of-range: request is still granted, to avoid a core hang. Response has rvalid=1, err=1, rdata=0.
- Load: when load_we_i=1, mem[load_idx_i] <= load_wdata_i at the edge and grant is suppressed that cycle. In-flight responses keep data captured at their grant, so a later load does not alter them.
- gnt_cnt_o increments on each cycle with instr_gnt_o=1 and saturates at 16'hFFFF.
- Reset mid-operation: all outstanding responses are dropped (no rvalid after reset release for pre-reset grants). Memory contents are retained.

Optional Feature:
Macro INSTR_MEM_GNT_STALL_EN.
- Defined: adds an 8-bit Fibonacci LFSR (taps 8,6,5,4), reset to 8'hA5, advancing every cycle. Grant is additionally suppressed when lfsr[1:0]==2'b00, giving pseudo-random grant stalls to exercise core fetch stalls. Requests are never lost; the core holds req/addr until granted.
- Undefined: no LFSR; grant depends only on instr_req_i and load_we_i.

Test Plan:
- Preload idx0..3 = 32'h00000433, 32'h000004B3, 32'h00F00293, 32'h00048663; READ_LATENCY=1; req addr 0x0,0x4,0x8,0xC back-to-back -> gnt 1 every cycle, rvalid on the 4 following cycles with those words in order, err=0, gnt_cnt_o=4.
- READ_LATENCY=3, single req addr 0x8 -> rvalid exactly 3 cycles after grant edge with rdata 32'h00F00293; rvalid low otherwise.
- req addr 0x40 (N_WORDS=16, BASE 0) -> gnt=1; response rvalid=1, err=1, rdata=0. req addr 0x3C -> err=0, data mem[15].
- load_we_i=1 in same cycle as req -> gnt=0. Next cycle req granted and returns newly loaded word. Load to idx 2 one cycle after grant of 0x8 -> response returns old value.
- READ_LATENCY=2, grants at cycles 0 and 1, rst_n low at cycle 1.5 for 1 cycle -> rvalid stays 0 through and after reset; gnt_cnt_o=0; memory read back intact.
- INSTR_MEM_GNT_STALL_EN defined, req held 50 cycles with addr stepping only on grant -> gnt low exactly on lfsr[1:0]==0 cycles (first pattern from seed 8'hA5); every address returns exactly once, in order.

Source files
------------

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: memory-side end of the core's instruction fetch port.
// Holds N_WORDS 32-bit words, grants fetch requests and returns read data
// after a fixed READ_LATENCY through a pipeline that accepts one request per cycle.
// A preload port writes program words. Out-of-range fetches are still granted
// and answered with err=1, rdata=0 so the core never hangs.
// Optional build macro: INSTR_MEM_GNT_STALL_EN adds LFSR-driven grant stalls.
module instr_mem_responder #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    N_WORDS      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    READ_LATENCY = 1,
    parameter int                    IDX_W        = $clog2(N_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [31:0]           instr_rdata_o,
    output logic                  instr_err_o,
    input  logic                  load_we_i,
    input  logic [IDX_W-1:0]      load_idx_i,
    input  logic [31:0]           load_wdata_i,
    output logic [15:0]           gnt_cnt_o
);

    // One extra bit so BASE_ADDR + 4*N_WORDS cannot wrap at the top of the map.
    localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] LIMIT_EXT = BASE_EXT + (ADDR_WIDTH+1)'(4 * N_WORDS);

    logic [31:0]             mem [N_WORDS];
    logic                    gnt;
    logic                    stall;
    logic                    in_range;
    logic [ADDR_WIDTH:0]     addr_ext;
    logic [IDX_W-1:0]        idx;
    logic [READ_LATENCY-1:0] valid_reg;
    logic [READ_LATENCY-1:0] err_reg;
    logic [31:0]             data_reg [READ_LATENCY];
    logic [15:0]             gnt_cnt_reg;

`ifdef INSTR_MEM_GNT_STALL_EN
    logic [7:0] lfsr_reg;
    logic       lfsr_fb;

    assign lfsr_fb = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

    // Free-running Fibonacci LFSR (taps 8,6,5,4) that schedules grant stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= 8'hA5;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0], lfsr_fb};
        end
    end

    assign stall = (lfsr_reg[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Grant is purely combinational: the pipeline always has room for one more.
    assign gnt         = instr_req_i & ~load_we_i & ~stall;
    assign instr_gnt_o = gnt;

    // Base is word aligned, so the index is a subtraction on the word bits only;
    // the byte-offset bits addr[1:0] take no part.
    assign addr_ext = {1'b0, instr_addr_i};
    assign in_range = (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
    assign idx      = instr_addr_i[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];

    // Preload write port; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (load_we_i) begin
            mem[load_idx_i] <= load_wdata_i;
        end
    end

    // Response pipeline: stage 0 samples the array in the grant cycle, later
    // stages shift. Data/err only move with a valid entry so the last stage
    // keeps the most recent response when nothing is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            err_reg   <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_reg[i] <= 32'h0;
            end
        end else begin
            valid_reg[0] <= gnt;
            if (gnt) begin
                err_reg[0]  <= ~in_range;
                data_reg[0] <= in_range ? mem[idx] : 32'h0;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                if (valid_reg[i-1]) begin
                    err_reg[i]  <= err_reg[i-1];
                    data_reg[i] <= data_reg[i-1];
                end
            end
        end
    end

    assign instr_rvalid_o = valid_reg[READ_LATENCY-1];
    assign instr_err_o    = valid_reg[READ_LATENCY-1] & err_reg[READ_LATENCY-1];
    assign instr_rdata_o  = data_reg[READ_LATENCY-1];

    // Saturating count of granted requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt_reg <= 16'h0;
        end else if (gnt && (gnt_cnt_reg != 16'hFFFF)) begin
            gnt_cnt_reg <= gnt_cnt_reg + 16'h1;
        end
    end

    assign gnt_cnt_o = gnt_cnt_reg;

endmodule
